// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline sequencer: per-register control command and FSM state.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipeline_pkg;

    // Command applied to one inter-stage pipeline register.
    typedef enum logic [1:0] {
        CONTINUE = 2'b00,
        STALL    = 2'b01,
        FLUSH    = 2'b10
    } pipeline_control_t;

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10,
        FAULT    = 2'b11
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator between the decode sources and the execute-stage load.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the result feeds the sequencer's priority mux.
//
// Ports: dec_rs1_i/dec_rs2_i + dec_uses_rs*_i describe decode sources,
//        ex_rd_i/ex_is_load_i describe the execute instruction, load_use_o flags the hazard.
module pipe_ctrl_hazard_detect (
    input  logic [4:0] dec_rs1_i,
    input  logic [4:0] dec_rs2_i,
    input  logic       dec_uses_rs1_i,
    input  logic       dec_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_load_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = dec_uses_rs1_i && (dec_rs1_i == ex_rd_i);
    assign rs2_hit = dec_uses_rs2_i && (dec_rs2_i == ex_rd_i);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// Central five-stage pipeline sequencer: boot hold, mem/redirect/load-use/fetch arbitration, mem timeout fault.
// Latency: 0 cycles; control outputs are combinational from registered state and current inputs.
// Backpressure: memory not ready stalls fd/de/em and bubbles mw; fetch not ready flushes fd; FAULT freezes all.
//
// Ports: clk_i/rst_ni (async active-low); decode/execute/memory hazard inputs; pc_en_o and
//        fd/de/em/mw_ctrl_o commands; mem_timeout_o sticky fault; stall_cycles_o/redirect_count_o counters.
// Optional: PIPE_CTRL_PERF_EN enables the saturating performance counters (tied to 0 otherwise).
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [4:0]           dec_rs1_i,
    input  logic [4:0]           dec_rs2_i,
    input  logic                 dec_uses_rs1_i,
    input  logic                 dec_uses_rs2_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 ex_is_load_i,
    input  logic                 ex_redirect_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    input  logic                 imem_ready_i,
    output logic                 pc_en_o,
    output pipeline_control_t    fd_ctrl_o,
    output pipeline_control_t    de_ctrl_o,
    output pipeline_control_t    em_ctrl_o,
    output pipeline_control_t    mw_ctrl_o,
    output logic                 mem_timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o,
    output logic [CNT_WIDTH-1:0] redirect_count_o
);

    // With MEM_TIMEOUT=0 the wait counter just saturates at all-ones and never faults.
    localparam logic [31:0] WAIT_SAT = (MEM_TIMEOUT == 0) ? 32'hFFFF_FFFF : 32'(MEM_TIMEOUT);

    ctrl_state_t state_q;
    logic [31:0] boot_cnt_q;
    logic [31:0] wait_cnt_q;
    logic        load_use;
    logic        mem_stall;
    logic        boot_done;
    logic        running;

    pipe_ctrl_hazard_detect u_hazard (
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_uses_rs1_i (dec_uses_rs1_i),
        .dec_uses_rs2_i (dec_uses_rs2_i),
        .ex_rd_i        (ex_rd_i),
        .ex_is_load_i   (ex_is_load_i),
        .load_use_o     (load_use)
    );

    assign mem_stall     = mem_req_i && !mem_ready_i;
    assign running       = (state_q == RUN) || (state_q == MEM_WAIT);
    assign mem_timeout_o = (state_q == FAULT);

    // The current BOOT cycle is the BOOT_CYCLES-th one when the post-increment count
    // reaches BOOT_CYCLES, so the pipeline is held for exactly BOOT_CYCLES cycles.
    assign boot_done = (boot_cnt_q + 32'd1) >= 32'(BOOT_CYCLES);

    // Fixed-priority command mux: memory stall > redirect > load-use > fetch wait.
    // A redirect seen during a memory stall is held by the stalled execute register
    // and naturally wins on the cycle the stall clears.
    always_comb begin
        pc_en_o   = 1'b0;
        fd_ctrl_o = FLUSH;
        de_ctrl_o = FLUSH;
        em_ctrl_o = FLUSH;
        mw_ctrl_o = FLUSH;
        case (state_q)
            BOOT: begin
            end
            FAULT: begin
                fd_ctrl_o = STALL;
                de_ctrl_o = STALL;
                em_ctrl_o = STALL;
                mw_ctrl_o = STALL;
            end
            default: begin
                if (mem_stall) begin
                    fd_ctrl_o = STALL;
                    de_ctrl_o = STALL;
                    em_ctrl_o = STALL;
                    mw_ctrl_o = FLUSH;
                end else if (ex_redirect_i) begin
                    pc_en_o   = 1'b1;
                    fd_ctrl_o = FLUSH;
                    de_ctrl_o = FLUSH;
                    em_ctrl_o = CONTINUE;
                    mw_ctrl_o = CONTINUE;
                end else if (load_use) begin
                    fd_ctrl_o = STALL;
                    de_ctrl_o = FLUSH;
                    em_ctrl_o = CONTINUE;
                    mw_ctrl_o = CONTINUE;
                end else if (!imem_ready_i) begin
                    fd_ctrl_o = FLUSH;
                    de_ctrl_o = CONTINUE;
                    em_ctrl_o = CONTINUE;
                    mw_ctrl_o = CONTINUE;
                end else begin
                    pc_en_o   = 1'b1;
                    fd_ctrl_o = CONTINUE;
                    de_ctrl_o = CONTINUE;
                    em_ctrl_o = CONTINUE;
                    mw_ctrl_o = CONTINUE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    if (boot_cnt_q < 32'(BOOT_CYCLES)) begin
                        boot_cnt_q <= boot_cnt_q + 32'd1;
                    end
                    if (boot_done && imem_ready_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    wait_cnt_q <= '0;
                    if (mem_stall) begin
                        state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_i) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else begin
                        if (wait_cnt_q != WAIT_SAT) begin
                            wait_cnt_q <= wait_cnt_q + 32'd1;
                        end
                        if ((MEM_TIMEOUT != 0) && ((wait_cnt_q + 32'd1) >= WAIT_SAT)) begin
                            state_q <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    // Only reset leaves FAULT.
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] redir_cnt_q;
    logic                 redirect_fire;

    assign redirect_fire = running && !mem_stall && ex_redirect_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (running && !pc_en_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect_fire && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cycles_o   = stall_cnt_q;
    assign redirect_count_o = redir_cnt_q;
`else
    logic unused_running;
    assign unused_running   = running;
    assign stall_cycles_o   = '0;
    assign redirect_count_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: stimulus pushes model predictions, a negedge monitor pops and compares.
// Latency: expectations are for the same cycle the inputs are applied.
// Backpressure: n/a (bench).
module tb_pipeline_controller;

    localparam int BOOT_N = 2;
    localparam int TMO    = 4;
    localparam int CW     = 32;

    localparam logic [1:0] C_CONT  = 2'b00;
    localparam logic [1:0] C_STALL = 2'b01;
    localparam logic [1:0] C_FLUSH = 2'b10;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic [4:0]    dec_rs1, dec_rs2, ex_rd;
    logic          dec_uses_rs1, dec_uses_rs2, ex_is_load, ex_redirect;
    logic          mem_req, mem_ready, imem_ready;
    logic          pc_en, mem_timeout;
    logic [1:0]    fd_ctrl, de_ctrl, em_ctrl, mw_ctrl;
    logic [CW-1:0] stall_cycles, redirect_count;

    pipeline_controller #(
        .BOOT_CYCLES (BOOT_N),
        .MEM_TIMEOUT (TMO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .dec_rs1_i        (dec_rs1),
        .dec_rs2_i        (dec_rs2),
        .dec_uses_rs1_i   (dec_uses_rs1),
        .dec_uses_rs2_i   (dec_uses_rs2),
        .ex_rd_i          (ex_rd),
        .ex_is_load_i     (ex_is_load),
        .ex_redirect_i    (ex_redirect),
        .mem_req_i        (mem_req),
        .mem_ready_i      (mem_ready),
        .imem_ready_i     (imem_ready),
        .pc_en_o          (pc_en),
        .fd_ctrl_o        (fd_ctrl),
        .de_ctrl_o        (de_ctrl),
        .em_ctrl_o        (em_ctrl),
        .mw_ctrl_o        (mw_ctrl),
        .mem_timeout_o    (mem_timeout),
        .stall_cycles_o   (stall_cycles),
        .redirect_count_o (redirect_count)
    );

    typedef struct packed {
        logic [1:0]  fd, de, em, mw;
        logic        pc, to;
        logic [31:0] sc, rc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain flags and counts describing where the pipeline is.
    bit m_booting;
    int m_boot_seen;
    bit m_waiting;
    int m_wait_n;
    bit m_faulted;
    int m_stalls;
    int m_redirs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t cmd(input logic [1:0] f, d, e, m, input logic p);
        exp_t x;
        x    = '0;
        x.fd = f; x.de = d; x.em = e; x.mw = m; x.pc = p;
        return x;
    endfunction

    // Predict this cycle's outputs from the current inputs, push them, then advance one cycle.
    task automatic step();
        exp_t e;
        bit   hazard;
        if (!rst_ni) begin
            m_booting = 1; m_boot_seen = 0; m_waiting = 0; m_wait_n = 0;
            m_faulted = 0; m_stalls = 0; m_redirs = 0;
            e = cmd(C_FLUSH, C_FLUSH, C_FLUSH, C_FLUSH, 1'b0);
        end else if (m_faulted) begin
            e    = cmd(C_STALL, C_STALL, C_STALL, C_STALL, 1'b0);
            e.to = 1'b1;
            e.sc = m_stalls; e.rc = m_redirs;
        end else if (m_booting) begin
            e = cmd(C_FLUSH, C_FLUSH, C_FLUSH, C_FLUSH, 1'b0);
            e.sc = m_stalls; e.rc = m_redirs;
            m_boot_seen++;
            if (m_boot_seen >= BOOT_N && imem_ready) m_booting = 0;
        end else begin
            hazard = ex_is_load && (ex_rd != 0) &&
                     ((dec_uses_rs1 && dec_rs1 == ex_rd) || (dec_uses_rs2 && dec_rs2 == ex_rd));
            if (mem_req && !mem_ready)  e = cmd(C_STALL, C_STALL, C_STALL, C_FLUSH, 1'b0);
            else if (ex_redirect)       e = cmd(C_FLUSH, C_FLUSH, C_CONT,  C_CONT,  1'b1);
            else if (hazard)            e = cmd(C_STALL, C_FLUSH, C_CONT,  C_CONT,  1'b0);
            else if (!imem_ready)       e = cmd(C_FLUSH, C_CONT,  C_CONT,  C_CONT,  1'b0);
            else                        e = cmd(C_CONT,  C_CONT,  C_CONT,  C_CONT,  1'b1);
            e.sc = m_stalls; e.rc = m_redirs;
            if (PERF_ON && !e.pc) m_stalls++;
            if (PERF_ON && !(mem_req && !mem_ready) && ex_redirect) m_redirs++;
            if (!m_waiting) begin
                if (mem_req && !mem_ready) begin
                    m_waiting = 1; m_wait_n = 0;
                end
            end else if (mem_ready) begin
                m_waiting = 0;
            end else begin
                m_wait_n++;
                if (m_wait_n >= TMO) m_faulted = 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_ni = 1; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
        ex_rd = 0; ex_is_load = 0; ex_redirect = 0; mem_req = 0; mem_ready = 1; imem_ready = 1;
    endtask

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fd_ctrl",        32'(fd_ctrl),     32'(e.fd));
            chk("de_ctrl",        32'(de_ctrl),     32'(e.de));
            chk("em_ctrl",        32'(em_ctrl),     32'(e.em));
            chk("mw_ctrl",        32'(mw_ctrl),     32'(e.mw));
            chk("pc_en",          32'(pc_en),       32'(e.pc));
            chk("mem_timeout",    32'(mem_timeout), 32'(e.to));
            chk("stall_cycles",   stall_cycles,     e.sc);
            chk("redirect_count", redirect_count,   e.rc);
        end
    end

    initial begin
        idle_inputs();
        rst_ni = 0;
        @(posedge clk);
        #1;
        // Reset held, then boot: two FLUSH cycles and then normal flow.
        step(); step();
        rst_ni = 1;
        repeat (4) step();

        // Load-use on rs2, then the load moves on.
        ex_is_load = 1; ex_rd = 5; dec_rs2 = 5; dec_uses_rs2 = 1;
        step();
        ex_is_load = 0;
        step();
        // Load to x0 never stalls.
        ex_is_load = 1; ex_rd = 0; dec_rs2 = 0;
        step();
        idle_inputs();
        step();

        // Redirect.
        ex_redirect = 1;
        step();
        ex_redirect = 0;
        step();

        // Memory wait with a pending redirect, applied when memory completes.
        mem_req = 1; mem_ready = 0; ex_redirect = 1;
        repeat (3) step();
        mem_ready = 1;
        step();
        idle_inputs();
        step();

        // Ten load-use bubbles.
        for (int i = 0; i < 10; i++) begin
            ex_is_load = 1; ex_rd = 7; dec_rs1 = 7; dec_uses_rs1 = 1;
            step();
            ex_is_load = 0;
            step();
        end
        idle_inputs();

        // Randomized traffic; memory is forced ready before the timeout can trigger.
        for (int i = 0; i < 500; i++) begin
            dec_rs1      = 5'($urandom_range(0, 3));
            dec_rs2      = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            dec_uses_rs1 = 1'($urandom_range(0, 1));
            dec_uses_rs2 = 1'($urandom_range(0, 1));
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_redirect  = ($urandom_range(0, 5) == 0);
            imem_ready   = ($urandom_range(0, 4) != 0);
            mem_req      = ($urandom_range(0, 2) == 0);
            mem_ready    = ($urandom_range(0, 4) < 3);
            if (m_waiting && m_wait_n >= 2) mem_ready = 1;
            step();
        end
        idle_inputs();
        step();

        // Timeout: four MEM_WAIT cycles without ready, then sticky FAULT.
        mem_req = 1; mem_ready = 0;
        repeat (8) step();
        // Asynchronous reset mid-cycle returns to boot values immediately.
        rst_ni = 0;
        step();
        // Boot with fetch not ready past the boot count, then release.
        idle_inputs();
        imem_ready = 0;
        repeat (3) step();
        imem_ready = 1;
        repeat (4) step();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central pipeline sequencer for the five-stage core. Generates the `pipeline_control_t` command (CONTINUE/STALL/FLUSH) for the fetch/decode, decode/execute, execute/memory and memory/writeback registers, plus the PC enable. It resolves load-use hazards, branch/jump redirects, instruction-fetch wait and data-memory wait. It also sequences boot hold and a data-memory timeout fault.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles the pipeline is held flushed after reset release.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before FAULT; 0 disables the timeout.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- dec_rs1_i, dec_rs2_i  in  5 each  source registers of the instruction in decode.
- dec_uses_rs1_i, dec_uses_rs2_i  in  1 each  the decode instruction actually reads that source.
- ex_rd_i  in  5  destination register of the instruction in execute.
- ex_is_load_i  in  1  the execute instruction is a load.
- ex_redirect_i  in  1  a taken branch or jump resolved in execute.
- mem_req_i  in  1  the memory stage holds a load or store.
- mem_ready_i  in  1  data memory completes the access this cycle.
- imem_ready_i  in  1  instruction memory returns a valid word this cycle.
- pc_en_o  out  1  PC register update enable.
- fd_ctrl_o, de_ctrl_o, em_ctrl_o, mw_ctrl_o  out  2 each  pipeline_control_t for each pipeline register.
- mem_timeout_o  out  1  sticky fault flag.
- stall_cycles_o, redirect_count_o  out  CNT_WIDTH each  performance counters.

## Operation
State machine `ctrl_state_t` has four states: BOOT, RUN, MEM_WAIT and FAULT. Reset value is BOOT.

BOOT:
- All four control outputs are FLUSH; pc_en_o=0.
- The boot counter counts up to BOOT_CYCLES.
- The FSM goes to RUN on the first cycle where the count is reached and imem_ready_i=1.

RUN and MEM_WAIT use one fixed-priority evaluation. The first rule that matches decides the outputs:
1. **Memory stall** (mem_req_i & ~mem_ready_i): pc_en_o=0; fd/de/em = STALL; mw = FLUSH (bubble into writeback). Next state is MEM_WAIT.
2. **Redirect** (ex_redirect_i): pc_en_o=1; fd = FLUSH, de = FLUSH; em, mw = CONTINUE.
3. **Load-use** (ex_is_load_i & ex_rd_i≠0 & ((dec_uses_rs1_i & dec_rs1_i==ex_rd_i) | (dec_uses_rs2_i & dec_rs2_i==ex_rd_i))): pc_en_o=0; fd = STALL; de = FLUSH; em, mw = CONTINUE.
4. **Fetch wait** (~imem_ready_i): pc_en_o=0; fd = FLUSH; de, em, mw = CONTINUE.
5. **Otherwise:** all CONTINUE; pc_en_o=1.

Rule notes:
- A redirect that arrives during a memory stall is not lost. ex_redirect_i is held by the stalled execute register and is applied on the cycle the stall ends.
- x0 never causes a load-use hazard.

MEM_WAIT:
- The wait counter increments every MEM_WAIT cycle.
- When mem_ready_i=1 the FSM returns to RUN and the wait counter clears.
- If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while mem_ready_i=0, the FSM goes to FAULT.

FAULT:
- All four control outputs are STALL; pc_en_o=0; mem_timeout_o=1.
- The FSM stays in FAULT until reset.

## Timing
- Control outputs and pc_en_o are combinational from the registered state and the current inputs. Latency is 0 cycles.
- The state, boot counter, wait counter and perf counters are registered.
- Reset values:
  - state = BOOT
  - all control outputs = FLUSH
  - pc_en_o = 0
  - mem_timeout_o = 0
  - all counters = 0
- If reset asserts mid-stall or in FAULT, everything returns immediately to the BOOT values.
- The load-use bubble lasts exactly 1 cycle. Next cycle the load has moved to memory, so rule 3 no longer matches.
- The wait counter saturates at MEM_TIMEOUT; it never wraps.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - stall_cycles_o increments on every RUN or MEM_WAIT cycle with pc_en_o=0.
  - redirect_count_o increments on every cycle where rule 2 fires.
  - Both counters saturate at all-ones.
- `PIPE_CTRL_PERF_EN` undefined: both ports stay in the interface but are tied to 0, and no counter flops exist.

## Structure
- Shared package `pipeline_pkg` holds:
  - `pipeline_control_t` (CONTINUE=2'b00, STALL=2'b01, FLUSH=2'b10)
  - `ctrl_state_t`
- Sub-module `pipe_ctrl_hazard_detect` holds the purely combinational load-use comparator, outputting `load_use_o`. The FSM, counters and priority mux stay in the top level.

## Test plan
- **Reset/boot:** release rst_ni with imem_ready_i=1 → outputs FLUSH and pc_en_o=0 for 2 cycles, then all CONTINUE with pc_en_o=1.
- **Load-use:** ex_is_load_i=1, ex_rd_i=5, dec_rs2_i=5, dec_uses_rs2_i=1 → one cycle with fd=STALL, de=FLUSH, pc_en_o=0. Repeat with ex_rd_i=0 → no stall.
- **Redirect:** ex_redirect_i=1 → fd=de=FLUSH, pc_en_o=1, redirect_count_o +1 (macro on).
- **Memory wait:** mem_req_i=1, mem_ready_i=0 for 3 cycles while ex_redirect_i=1 → fd/de/em=STALL, mw=FLUSH for 3 cycles. Then mem_ready_i=1 → redirect flush applied that cycle.
- **Timeout:** MEM_TIMEOUT=4, mem_ready_i held 0 → FAULT after 4 MEM_WAIT cycles, mem_timeout_o=1 sticky, all STALL. Assert rst_ni=0 → BOOT values immediately.
- **Perf counters:** 10 load-use stalls → stall_cycles_o=10 with macro on, 0 with macro off.
